div_controller: RTL
===================

DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port ctrl_div, input, 1 bit, start request sampled on the rising edge.
REQ-004 SHALL have port data_operandA, input, 32 bits, dividend, captured on an accepted start.
REQ-005 SHALL have port data_operandB, input, 32 bits, divisor, captured on an accepted start.
REQ-006 SHALL have port data_result, output, 32 bits, registered quotient.
REQ-007 SHALL have port data_exception, output, 1 bit, registered divide-by-zero flag.
REQ-008 SHALL have port data_resultRDY, output, 1 bit, one-cycle completion pulse.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-010 SHALL accept ctrl_div=1 in any state; in RUN or FIX this aborts the current division and restarts with the new operands.
REQ-011 SHALL, on accept at edge N: latch |A|, |B| and the sign flags; load 64-bit RQ={32'b0,|A|}; set prevMSB=0 and count=0; go to RUN.
REQ-012 SHALL, each RUN edge, perform one non-restoring step.
- Shift RQ left 1.
- Add -|B| to RQ[63:32] if prevMSB=0, else +|B|.
- Set RQ[0] = inverted sign bit of the new RQ[63:32].
- Update prevMSB to that sign bit.
- Increment count.
REQ-013 SHALL leave RUN for FIX on the edge that completes step 32, which is edge N+32.
REQ-014 SHALL, at the FIX edge N+33, register data_result = quotient RQ[31:0], negated (two's complement) when the operand signs differ; clear data_exception; go to DONE.
REQ-015 SHALL assert data_resultRDY=1 exactly during DONE, the cycle after edge N+33, then return to IDLE.
REQ-016 SHALL, when the latched divisor is 0, skip RUN: at edge N+1 set data_result=0, data_exception=1 and enter DONE.
REQ-017 SHALL hold data_result and data_exception stable from DONE until the next completion.
REQ-018 SHALL treat 0x80000000 / 0xFFFFFFFF (signed) as wrap-around: result 0x80000000, exception 0.
REQ-019 SHALL treat ctrl_div=1 during DONE as a new start; data_resultRDY still pulses that cycle for the finished operation.
REQ-020 SHALL ignore operand changes when no accepted start occurs.

Reset
REQ-021 SHALL, on reset_n=0 at any time including mid-operation, immediately force the following:
- state=IDLE
- data_result=0
- data_exception=0
- data_resultRDY=0
- RQ=0, count=0, prevMSB=0
REQ-022 SHALL ignore ctrl_div while reset_n=0 and resume sampling on the first rising edge after deassertion.

Configuration
REQ-023 SHALL, with macro DIV_SIGNED_EN defined, treat operands as two's-complement and apply sign handling (REQ-011, REQ-014, REQ-018).
REQ-024 SHALL, without DIV_SIGNED_EN, treat operands as unsigned, take them as magnitudes directly, and never negate the result; REQ-018 does not apply.
REQ-025 SHALL keep latency and handshake identical in both configurations.

Verification
REQ-026 SHALL cover a basic divide: A=100, B=7, ctrl_div pulse at edge N -> data_resultRDY high only in cycle N+33..N+34, result=14, exception=0.
REQ-027 SHALL cover signed operands (DIV_SIGNED_EN):
- A=-100, B=7 -> result 0xFFFFFFF2 (-14).
- A=-100, B=-7 -> result 14.
REQ-028 SHALL cover divide-by-zero: A=5, B=0 -> data_resultRDY at cycle N+1, result=0, exception=1.
REQ-029 SHALL cover abort: start A=50, B=5; at edge N+10 restart with A=9, B=3 -> single RDY pulse at N+43, result=3; no pulse at N+33.
REQ-030 SHALL cover reset mid-operation: reset_n low at N+20 -> all outputs 0 asynchronously; no RDY pulse after release without a new start.
REQ-031 SHALL cover unsigned mode (no DIV_SIGNED_EN): A=0xFFFFFFFF, B=2 -> result 0x7FFFFFFF.

Source files
------------

// File: rtl/div_controller.sv
// -----------------------------------------------------------------------------
// div_controller
//   Sequential 32-bit divider: one non-restoring step per clock, giving a
//   fixed latency of 33 edges from the accepted start to the result register.
//   A zero divisor completes on the first edge after the start and raises
//   data_exception.
//
//   Configuration macro: DIV_SIGNED_EN
//     defined   -> operands are two's complement. Magnitudes are divided, and
//                  the quotient is negated when the operand signs differ.
//     undefined -> operands are unsigned and the quotient is never negated.
//   Latency and handshake are the same in both builds.
//
// Ports
//   clock          in   1  sole clock, rising edge
//   reset_n        in   1  asynchronous active-low reset
//   ctrl_div       in   1  start request; accepted in every state (restarts)
//   data_operandA  in  32  dividend, captured on an accepted start
//   data_operandB  in  32  divisor, captured on an accepted start
//   data_result    out 32  registered quotient
//   data_exception out  1  registered divide-by-zero flag
//   data_resultRDY out  1  high for exactly the DONE cycle
// -----------------------------------------------------------------------------
module div_controller (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_div,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [63:0] rq_r;          // {partial remainder, dividend/quotient}
    logic [5:0]  count_r;
    logic        prev_msb_r;    // sign of the partial remainder
    logic [31:0] divisor_r;     // latched |B|
    logic        neg_result_r;  // operand signs differed

    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        start_neg_s;
    logic [32:0] shifted_s;
    logic [32:0] sum_s;
    logic        new_sign_s;
    logic [63:0] rq_step_s;
    logic        divisor_zero_s;
    logic [31:0] quotient_s;

    // Two's-complement magnitude of a 32-bit value.
    function automatic logic [31:0] magnitude(input logic [31:0] value);
        magnitude = value[31] ? (~value + 32'd1) : value;
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [31:0] apply_sign(input logic [31:0] value,
                                               input logic        negate);
        apply_sign = negate ? (~value + 32'd1) : value;
    endfunction

    // Operand conditioning for a start request.
    always_comb begin
`ifdef DIV_SIGNED_EN
        mag_a_s     = magnitude(data_operandA);
        mag_b_s     = magnitude(data_operandB);
        start_neg_s = data_operandA[31] ^ data_operandB[31];
`else
        mag_a_s     = data_operandA;
        mag_b_s     = data_operandB;
        start_neg_s = 1'b0;
`endif
    end

    // One non-restoring step. The sign flag is kept as a 33rd remainder bit,
    // so divisors with bit 31 set (up to 0xFFFFFFFF) still give a correct
    // sign. Arithmetic is modulo 2^33. This is exact because every
    // post-add remainder lies in [-|B|, |B|).
    always_comb begin
        shifted_s      = {rq_r[63:32], rq_r[31]};
        if (prev_msb_r) begin
            sum_s = shifted_s + {1'b0, divisor_r};
        end else begin
            sum_s = shifted_s - {1'b0, divisor_r};
        end
        new_sign_s     = sum_s[32];
        rq_step_s      = {sum_s[31:0], rq_r[30:0], ~new_sign_s};
        divisor_zero_s = (divisor_r == 32'd0);
        quotient_s     = apply_sign(rq_r[31:0], neg_result_r);
    end

    // Next-state logic; a start request overrides every state.
    always_comb begin
        state_next_s = state_r;
        if (ctrl_div) begin
            state_next_s = RUN;
        end else begin
            case (state_r)
                IDLE: state_next_s = IDLE;
                RUN: begin
                    if (divisor_zero_s) begin
                        state_next_s = DONE;
                    end else if (count_r == 6'd31) begin
                        state_next_s = FIX;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FIX:     state_next_s = DONE;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Division datapath: load on start, step while in RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rq_r         <= 64'd0;
            count_r      <= 6'd0;
            prev_msb_r   <= 1'b0;
            divisor_r    <= 32'd0;
            neg_result_r <= 1'b0;
        end else if (ctrl_div) begin
            rq_r         <= {32'd0, mag_a_s};
            count_r      <= 6'd0;
            prev_msb_r   <= 1'b0;
            divisor_r    <= mag_b_s;
            neg_result_r <= start_neg_s;
        end else if ((state_r == RUN) && !divisor_zero_s) begin
            rq_r         <= rq_step_s;
            count_r      <= count_r + 6'd1;
            prev_msb_r   <= new_sign_s;
        end
    end

    // Result registers: written only when an operation actually completes,
    // so an abort leaves the previous result intact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (!ctrl_div && (state_r == FIX)) begin
            data_result    <= quotient_s;
            data_exception <= 1'b0;
        end else if (!ctrl_div && (state_r == RUN) && divisor_zero_s) begin
            data_result    <= 32'd0;
            data_exception <= 1'b1;
        end
    end

    // Ready flag: registered copy of "state is DONE".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state_next_s == DONE);
        end
    end

endmodule
